l2cache_nway_control: RTL and testbench
=======================================

// Module: l2cache_nway_control
// PURPOSE
//  Control FSM for a WAYS-way set-associative write-back L2 cache, between the CPU-side Wishbone slave port and
//  the physical-memory Wishbone master port. Drives per-way data/valid/dirty/LRU write strobes; datapath holds arrays.
//  Successor to the 2-way control: parametrised ways, invalid-way-first victim choice, latched victim,
//  mem_rty retry with bounded count, cpu_err on retry exhaustion, misses only on a real CPU request.
// PARAMETERS
//  WAYS       4   number of ways; power of two, >=2
//  WAY_W      $clog2(WAYS)  way index width (derived, do not override)
//  MAX_RETRY  8   consecutive mem_rty tolerated per miss before abort; >=1
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst_n          in   1      synchronous active-low reset
//  cpu_cyc        in   1      CPU bus cycle
//  cpu_stb        in   1      CPU strobe; request = cpu_cyc & cpu_stb
//  cpu_we         in   1      1 = write request
//  cpu_ack        out  1      request complete (comb. on hit in IDLE)
//  cpu_err        out  1      miss aborted after MAX_RETRY retries (1-cycle pulse)
//  hit_vec        in   WAYS   per-way tag match & valid for current address
//  valid_vec      in   WAYS   valid bits of indexed set
//  dirty_vec      in   WAYS   dirty bits of indexed set
//  lru_victim     in   WAY_W  LRU way of indexed set (from datapath LRU array)
//  way_write      out  WAYS   data-array write enable per way
//  meta_write     out  WAYS   valid+dirty write enable per way
//  valid_in       out  1      valid value for ways with meta_write
//  dirty_in       out  1      dirty value for ways with meta_write
//  lru_write      out  1      update LRU of indexed set
//  lru_way        out  WAY_W  way just accessed (MRU)
//  victim_way     out  WAY_W  latched victim, selects writeback data/tag mux
//  datainmux_sel  out  1      1 = CPU data into array, 0 = memory data
//  memaddrmux_sel out  1      1 = victim tag address (writeback), 0 = CPU address
//  mem_cyc        out  1      memory bus cycle
//  mem_stb        out  1      memory strobe
//  mem_we         out  1      memory write
//  mem_ack        in   1      memory transfer done
//  mem_rty        in   1      memory asks retry
// BEHAVIOUR
//  Reset: rst_n low at an edge -> state IDLE, victim_q=0, retry_cnt=0, ret_state=ALLOCATE. While rst_n low all
//   outputs forced 0 combinationally; a transfer in flight is abandoned (mem_cyc drops same cycle).
//  Hit way h = lowest index set in hit_vec; hit = |hit_vec. Multi-hit resolves to lowest index.
//  States: IDLE, WRITE_BACK, STROBE, ALLOCATE, RETRY_WAIT, ERROR.
//  IDLE: req & hit -> cpu_ack=1, lru_write=1, lru_way=h; if cpu_we also datainmux_sel=1, way_write[h]=1,
//   meta_write[h]=1, valid_in=1, dirty_in=1. Stay IDLE. 0-cycle hit latency.
//   req & !hit -> victim v = lowest invalid way if ~&valid_vec, else lru_victim; victim_q<=v; retry_cnt<=0;
//   next WRITE_BACK if valid_vec[v]&dirty_vec[v], else ALLOCATE. No req -> stay IDLE, all outputs 0.
//  WRITE_BACK: mem_cyc=mem_stb=mem_we=1, memaddrmux_sel=1. mem_ack -> STROBE; else mem_rty -> RETRY_WAIT
//   (ret_state<=WRITE_BACK); else stay.
//  STROBE: mem_cyc=mem_stb=0 one cycle -> ALLOCATE.
//  ALLOCATE: mem_cyc=mem_stb=1, mem_we=0, datainmux_sel=0. On mem_ack cycle only: way_write[victim_q]=1,
//   meta_write[victim_q]=1, valid_in=1, dirty_in=0; next IDLE (request then hits, acked there).
//   Else mem_rty -> RETRY_WAIT (ret_state<=ALLOCATE); else stay.
//  RETRY_WAIT: mem_cyc=mem_stb=0 one cycle; retry_cnt<=retry_cnt+1; if retry_cnt+1==MAX_RETRY -> ERROR, else ret_state.
//  ERROR: cpu_err=1 one cycle, no array writes -> IDLE.
//  mem_ack & mem_rty same cycle: ack wins. retry_cnt saturates, cleared only on new miss.
//  victim_way = victim_q at all times (stable across whole miss; datapath LRU changes ignored).
//  CPU dropping cyc/stb mid-miss: fill still completes, no ack, no error suppression.
//  lru_write only asserted in IDLE on a hit; never on allocate.
// TESTING
//  Read miss, set all valid, way2 LRU clean -> ALLOCATE, way_write=4'b0100 on ack, next cycle cpu_ack, lru_way=2.
//  Write miss, valid_vec=4'b1011 -> victim 2 (invalid) regardless of lru_victim=0; no writeback; then write-hit dirty_in=1.
//  Miss, victim 1 dirty -> mem_we=1 & memaddrmux_sel=1 until ack, 1 STROBE cycle, ALLOCATE, ack in IDLE.
//  ALLOCATE with 3 mem_rty then ack -> 3 RETRY_WAIT cycles with cyc=0, then fill; ack+rty same cycle = ack.
//  MAX_RETRY=8, mem_rty forever -> cpu_err pulse once after 8th retry, no way_write, back to IDLE.
//  rst_n low during WRITE_BACK -> mem_cyc=0 same cycle, IDLE next edge, next miss re-latches victim.

Source files
------------

// File: rtl/l2cache_nway_control.sv
// l2cache_nway_control: miss/fill/writeback sequencing for a WAYS-way write-back L2.
// The datapath owns the tag/data/valid/dirty/LRU arrays; this block only steers strobes and muxes.
module l2cache_nway_control #(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned WAY_W     = $clog2(WAYS),
  parameter int unsigned MAX_RETRY = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_cyc,
  input  logic             cpu_stb,
  input  logic             cpu_we,
  output logic             cpu_ack,
  output logic             cpu_err,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  input  logic [WAY_W-1:0] lru_victim,
  output logic [WAYS-1:0]  way_write,
  output logic [WAYS-1:0]  meta_write,
  output logic             valid_in,
  output logic             dirty_in,
  output logic             lru_write,
  output logic [WAY_W-1:0] lru_way,
  output logic [WAY_W-1:0] victim_way,
  output logic             datainmux_sel,
  output logic             memaddrmux_sel,
  output logic             mem_cyc,
  output logic             mem_stb,
  output logic             mem_we,
  input  logic             mem_ack,
  input  logic             mem_rty
);

  localparam int unsigned CNT_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, WRITE_BACK, STROBE, ALLOCATE, RETRY_WAIT, ERROR
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_state_q, ret_state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;

  logic             req;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] victim_sel;
  logic [CNT_W:0]   cnt_inc;

  assign req     = cpu_cyc & cpu_stb;
  assign hit     = |hit_vec;
  assign cnt_inc = {1'b0, retry_cnt_q} + (CNT_W + 1)'(1);

  // Lowest-index hit way and lowest-index invalid way (scan high to low so low index wins)
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (hit_vec[i])    hit_way  = WAY_W'(i);
      if (!valid_vec[i]) free_way = WAY_W'(i);
    end
    victim_sel = (~&valid_vec) ? free_way : lru_victim;
  end

  // Next-state and output decode; outputs are held low while reset is asserted
  always_comb begin
    state_d        = state_q;
    ret_state_d    = ret_state_q;
    victim_d       = victim_q;
    retry_cnt_d    = retry_cnt_q;
    cpu_ack        = 1'b0;
    cpu_err        = 1'b0;
    way_write      = '0;
    meta_write     = '0;
    valid_in       = 1'b0;
    dirty_in       = 1'b0;
    lru_write      = 1'b0;
    lru_way        = '0;
    victim_way     = victim_q;
    datainmux_sel  = 1'b0;
    memaddrmux_sel = 1'b0;
    mem_cyc        = 1'b0;
    mem_stb        = 1'b0;
    mem_we         = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            cpu_ack   = 1'b1;
            lru_write = 1'b1;
            lru_way   = hit_way;
            if (cpu_we) begin
              datainmux_sel       = 1'b1;
              way_write[hit_way]  = 1'b1;
              meta_write[hit_way] = 1'b1;
              valid_in            = 1'b1;
              dirty_in            = 1'b1;
            end
          end else begin
            victim_d    = victim_sel;
            retry_cnt_d = '0;
            state_d     = (valid_vec[victim_sel] && dirty_vec[victim_sel]) ? WRITE_BACK : ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        mem_cyc        = 1'b1;
        mem_stb        = 1'b1;
        mem_we         = 1'b1;
        memaddrmux_sel = 1'b1;
        if (mem_ack) begin
          state_d = STROBE;
        end else if (mem_rty) begin
          ret_state_d = WRITE_BACK;
          state_d     = RETRY_WAIT;
        end
      end
      STROBE: begin
        state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_cyc = 1'b1;
        mem_stb = 1'b1;
        if (mem_ack) begin
          way_write[victim_q]  = 1'b1;
          meta_write[victim_q] = 1'b1;
          valid_in             = 1'b1;
          state_d              = IDLE;
        end else if (mem_rty) begin
          ret_state_d = ALLOCATE;
          state_d     = RETRY_WAIT;
        end
      end
      RETRY_WAIT: begin
        if (retry_cnt_q != CNT_W'(MAX_RETRY)) retry_cnt_d = retry_cnt_q + CNT_W'(1);
        state_d = (cnt_inc == MAX_C) ? ERROR : ret_state_q;
      end
      ERROR: begin
        cpu_err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      cpu_ack        = 1'b0;
      cpu_err        = 1'b0;
      way_write      = '0;
      meta_write     = '0;
      valid_in       = 1'b0;
      dirty_in       = 1'b0;
      lru_write      = 1'b0;
      lru_way        = '0;
      victim_way     = '0;
      datainmux_sel  = 1'b0;
      memaddrmux_sel = 1'b0;
      mem_cyc        = 1'b0;
      mem_stb        = 1'b0;
      mem_we         = 1'b0;
    end
  end

  // State, latched victim, retry count and retry return point
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ret_state_q <= ALLOCATE;
      victim_q    <= '0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      victim_q    <= victim_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

endmodule

// File: tb/tb_l2cache_nway_control.sv
// Bench for l2cache_nway_control: bus-phase reference model compared every cycle, plus directed literal checks.
module tb_l2cache_nway_control;

  localparam int MAXR = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_cyc, cpu_stb, cpu_we;
  logic       cpu_ack, cpu_err;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic [1:0] lru_victim;
  logic [3:0] way_write, meta_write;
  logic       valid_in, dirty_in, lru_write;
  logic [1:0] lru_way, victim_way;
  logic       datainmux_sel, memaddrmux_sel;
  logic       mem_cyc, mem_stb, mem_we;
  logic       mem_ack, mem_rty;

  int n_tests = 0;
  int n_fail  = 0;

  l2cache_nway_control #(.WAYS(4), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_victim(lru_victim),
    .way_write(way_write), .meta_write(meta_write), .valid_in(valid_in), .dirty_in(dirty_in),
    .lru_write(lru_write), .lru_way(lru_way), .victim_way(victim_way),
    .datainmux_sel(datainmux_sel), .memaddrmux_sel(memaddrmux_sel),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rty(mem_rty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: what the memory bus is doing for the current request ----------------
  localparam int P_IDLE = 0, P_WB = 1, P_GAP = 2, P_FILL = 3, P_RW = 4, P_ERR = 5;
  int         m_ph;
  int         m_ret;
  int         m_cnt;
  logic [1:0] m_vic;
  bit         model_ok = 1'b0;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [1:0] pick_victim();
    if ($countones(valid_vec) < 4) return lowest_set(~valid_vec);
    return lru_victim;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = P_IDLE; m_ret = P_FILL; m_cnt = 0; m_vic = 2'd0; model_ok = 1'b1;
    end else if (model_ok) begin
      case (m_ph)
        P_IDLE: if (cpu_cyc && cpu_stb && hit_vec == 4'd0) begin
          m_vic = pick_victim();
          m_cnt = 0;
          m_ph  = (valid_vec[m_vic] && dirty_vec[m_vic]) ? P_WB : P_FILL;
        end
        P_WB:   if (mem_ack) m_ph = P_GAP; else if (mem_rty) begin m_ret = P_WB; m_ph = P_RW; end
        P_GAP:  m_ph = P_FILL;
        P_FILL: if (mem_ack) m_ph = P_IDLE; else if (mem_rty) begin m_ret = P_FILL; m_ph = P_RW; end
        P_RW:   begin m_cnt++; m_ph = (m_cnt >= MAXR) ? P_ERR : m_ret; end
        default: m_ph = P_IDLE;
      endcase
    end
  end

  function automatic logic [21:0] model_out();
    logic       ack = 0, err = 0, vi = 0, di = 0, lw = 0, dm = 0, am = 0, cy = 0, st = 0, we = 0;
    logic [3:0] ww = 0, mw = 0;
    logic [1:0] lway = 0, vw = 0;
    if (rst_n) begin
      vw = m_vic;
      case (m_ph)
        P_IDLE: if (cpu_cyc && cpu_stb && hit_vec != 4'd0) begin
          ack = 1; lw = 1; lway = lowest_set(hit_vec);
          if (cpu_we) begin dm = 1; ww = 4'b0001 << lway; mw = ww; vi = 1; di = 1; end
        end
        P_WB:   begin cy = 1; st = 1; we = 1; am = 1; end
        P_FILL: begin
          cy = 1; st = 1;
          if (mem_ack) begin ww = 4'b0001 << m_vic; mw = ww; vi = 1; end
        end
        P_ERR:  err = 1;
        default: ;
      endcase
    end
    return {ack, err, ww, mw, vi, di, lw, lway, vw, dm, am, cy, st, we};
  endfunction

  // Every-cycle compare, sampled mid-cycle
  always @(negedge clk) begin
    if (model_ok)
      chk("cycle", 32'({cpu_ack, cpu_err, way_write, meta_write, valid_in, dirty_in, lru_write,
                        lru_way, victim_way, datainmux_sel, memaddrmux_sel, mem_cyc, mem_stb, mem_we}),
          32'(model_out()));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic we, input logic [3:0] hv, input logic [3:0] vv,
                     input logic [3:0] dv, input logic [1:0] lru);
    cpu_cyc = 1; cpu_stb = 1; cpu_we = we;
    hit_vec = hv; valid_vec = vv; dirty_vec = dv; lru_victim = lru;
  endtask

  task automatic idle();
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; hit_vec = 0; mem_ack = 0; mem_rty = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps, errs, err_idx, writes;
    rst_n = 0; idle(); valid_vec = 0; dirty_vec = 0; lru_victim = 0;
    tick(); tick(); #1;
    chk("rst_mem_cyc", 32'(mem_cyc), 0);
    chk("rst_victim", 32'(victim_way), 0);
    chk("rst_ack", 32'(cpu_ack), 0);

    // Read miss, all valid, way2 LRU and clean
    tick(); rst_n = 1; req(0, 4'b0000, 4'b1111, 4'b0000, 2'd2); #1;
    chk("rd_miss_no_ack", 32'(cpu_ack), 0);
    tick(); #1;
    chk("rd_alloc_cyc", 32'(mem_cyc), 1);
    chk("rd_alloc_we", 32'(mem_we), 0);
    chk("rd_alloc_victim", 32'(victim_way), 2);
    tick(); mem_ack = 1; #1;
    chk("rd_fill_way_write", 32'(way_write), 32'h4);
    chk("rd_fill_dirty_in", 32'(dirty_in), 0);
    tick(); mem_ack = 0; hit_vec = 4'b0100; #1;
    chk("rd_hit_ack", 32'(cpu_ack), 1);
    chk("rd_hit_lru_way", 32'(lru_way), 2);
    tick(); idle();

    // Write miss with an invalid way: invalid way beats LRU, no writeback
    tick(); req(1, 4'b0000, 4'b1011, 4'b1111, 2'd0); #1;
    tick(); #1;
    chk("wr_alloc_we", 32'(mem_we), 0);
    chk("wr_alloc_victim", 32'(victim_way), 2);
    tick(); mem_ack = 1; #1;
    chk("wr_fill_way_write", 32'(way_write), 32'h4);
    tick(); mem_ack = 0; hit_vec = 4'b0100; #1;
    chk("wr_hit_dirty_in", 32'(dirty_in), 1);
    chk("wr_hit_way_write", 32'(way_write), 32'h4);
    chk("wr_hit_datamux", 32'(datainmux_sel), 1);
    tick(); idle();

    // Dirty victim way1: writeback, one gap cycle, then fill
    tick(); req(0, 4'b0000, 4'b1111, 4'b0010, 2'd1); #1;
    tick(); tick(); #1;
    chk("wb_mem_we", 32'(mem_we), 1);
    chk("wb_addrmux", 32'(memaddrmux_sel), 1);
    tick(); mem_ack = 1; #1;
    tick(); mem_ack = 0; #1;
    chk("wb_strobe_gap", 32'(mem_cyc), 0);
    tick(); #1;
    chk("wb_alloc_cyc", 32'(mem_cyc), 1);
    chk("wb_alloc_we", 32'(mem_we), 0);
    tick(); mem_ack = 1; #1;
    chk("wb_fill_way_write", 32'(way_write), 32'h2);
    tick(); mem_ack = 0; hit_vec = 4'b0010; #1;
    chk("wb_hit_ack", 32'(cpu_ack), 1);
    tick(); idle();

    // Fill with three retries, then ack and rty together (ack wins)
    tick(); req(0, 4'b0000, 4'b1111, 4'b0000, 2'd3); #1;
    tick(); mem_rty = 1; #1;
    gaps = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); mem_rty = 0; mem_ack = 0; #1;
      if (!mem_cyc) gaps++;
      tick(); mem_rty = 1; mem_ack = (k == 2); #1;
    end
    chk("retry_gaps", 32'(gaps), 3);
    chk("ack_beats_rty", 32'(way_write), 32'h8);
    tick(); mem_ack = 0; mem_rty = 0; hit_vec = 4'b1000; #1;
    chk("retry_hit_ack", 32'(cpu_ack), 1);
    tick(); idle();

    // Endless retry: one error pulse after the MAX_RETRY-th retry, never a write
    tick(); req(0, 4'b0000, 4'b1111, 4'b0000, 2'd0); #1;
    tick(); mem_rty = 1; #1;
    errs = 0; err_idx = -1; writes = 0;
    for (int idx = 1; idx < 30; idx++) begin
      tick(); #1;
      if (way_write != 0) writes++;
      if (cpu_err) begin errs++; err_idx = idx; cpu_cyc = 0; cpu_stb = 0; end
    end
    chk("err_pulses", 32'(errs), 1);
    chk("err_cycle", 32'(err_idx), 16);
    chk("err_no_write", 32'(writes), 0);
    chk("err_back_idle", 32'(mem_cyc), 0);
    tick(); idle();

    // Reset during writeback drops the bus at once; next miss latches a fresh victim
    tick(); req(0, 4'b0000, 4'b1111, 4'b0010, 2'd1); #1;
    tick(); #1;
    chk("rwb_cyc", 32'(mem_cyc), 1);
    rst_n = 0; #1;
    chk("rwb_rst_drops_cyc", 32'(mem_cyc), 0);
    tick(); rst_n = 1; req(0, 4'b0000, 4'b1111, 4'b1000, 2'd3); #1;
    chk("rwb_victim_cleared", 32'(victim_way), 0);
    tick(); #1;
    chk("rwb_new_victim", 32'(victim_way), 3);
    chk("rwb_new_wb", 32'(mem_we), 1);
    tick(); idle(); rst_n = 0;
    tick(); rst_n = 1;

    // Multi-hit resolves to lowest way
    tick(); req(0, 4'b0110, 4'b1111, 4'b0000, 2'd3); #1;
    chk("multihit_lru_way", 32'(lru_way), 1);
    chk("multihit_ack", 32'(cpu_ack), 1);
    tick(); idle();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
